// File: rtl/vfb_dma_pkg.sv
// Shared definitions for the frame-buffer DMA arbiter: FSM states, DDR command
// encodings and requester index helpers.
package vfb_dma_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_IDLE      = 2'd1,
        ST_GRANT     = 2'd2,
        ST_GAP       = 2'd3
    } arb_state_e;

    localparam logic REQ_WR = 1'b0;
    localparam logic REQ_RD = 1'b1;

    // Each channel owns an adjacent write/read requester pair.
    function automatic int wr_idx(input int ch);
        return 2 * ch;
    endfunction

    function automatic int rd_idx(input int ch);
        return 2 * ch + 1;
    endfunction

    function automatic int next_idx(input int idx, input int nreq);
        return (idx >= nreq - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/vfb_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping,
// returned both one-hot and as an index.
module vfb_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  pick,
    output logic [IDX_W-1:0] pick_idx
);

    logic [NREQ-1:0]  req_rot;
    logic [IDX_W-1:0] rot_idx;

    // NOTE: every variable gets a default before any conditional assignment so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_rot  = '0;
        rot_idx  = '0;
        pick     = '0;
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_rot[i] = req[(int'(ptr) + i) % NREQ];
        end
        // Scanning downward leaves the lowest rotated hit, i.e. closest to ptr.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_idx = IDX_W'(i);
            end
        end
        if (|req) begin
            pick_idx = IDX_W'((int'(rot_idx) + int'(ptr)) % NREQ);
            pick     = NREQ'(1) << pick_idx;
        end
    end

endmodule

// File: rtl/vfb_dma_rr_arbiter.sv
// Round-robin arbiter sharing one DDR user port between the write and read
// DMA requesters of NUM_CH frame-buffer channels.
module vfb_dma_rr_arbiter
    import vfb_dma_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int ADDR_WIDTH     = 26,
    parameter int DATA_WIDTH     = 64,
    parameter int MASK_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             init_done,
    input  logic [2*NUM_CH-1:0]              rq_req,
    input  logic [2*NUM_CH-1:0]              rq_end,
    output logic [2*NUM_CH-1:0]              rq_grant,
    input  logic [2*NUM_CH-1:0]              rq_cmd,
    input  logic [2*NUM_CH-1:0]              rq_cmd_en,
    input  logic [2*NUM_CH*ADDR_WIDTH-1:0]   rq_addr,
    input  logic [2*NUM_CH*DATA_WIDTH-1:0]   rq_wr_data,
    input  logic [2*NUM_CH*MASK_WIDTH-1:0]   rq_data_mask,
    output logic [2*NUM_CH-1:0]              rq_rd_valid,
    output logic [DATA_WIDTH-1:0]            rq_rd_data,
    output logic                             cmd,
    output logic                             cmd_en,
    output logic [ADDR_WIDTH-1:0]            addr,
    output logic [DATA_WIDTH-1:0]            wr_data,
    output logic [MASK_WIDTH-1:0]            data_mask,
    input  logic                             rd_data_valid,
    input  logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             err_timeout,
    output logic                             err_orphan
);

    localparam int NREQ  = 2 * NUM_CH;
    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_orphan_q, err_orphan_d;
    logic [NREQ-1:0]  pick;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_end;

    vfb_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (rq_req),
        .ptr      (ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    assign owner_end = rq_end[owner_q];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        err_timeout_d = err_timeout_q;
        err_orphan_d  = err_orphan_q | (rd_data_valid && (state_q != ST_GRANT));

        if (!init_done) begin
            state_d = ST_WAIT_INIT;
            grant_d = '0;
            ptr_d   = '0;
        end else begin
            unique case (state_q)
                ST_WAIT_INIT: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (|rq_req) begin
                        grant_d = pick;
                        owner_d = pick_idx;
                        cnt_d   = '0;
                        state_d = ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // A real end wins over a coincident timeout: no error then.
                    if (owner_end || (cnt_q == CNT_LAST)) begin
                        grant_d = '0;
                        ptr_d   = IDX_W'(next_idx(int'(owner_q), NREQ));
                        state_d = ST_GAP;
                        if (!owner_end) begin
                            err_timeout_d = 1'b1;
                        end
                    end
                end
                ST_GAP:  state_d = ST_IDLE;
                default: state_d = ST_WAIT_INIT;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_WAIT_INIT;
            grant_q       <= '0;
            owner_q       <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            err_timeout_q <= 1'b0;
            err_orphan_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            err_timeout_q <= err_timeout_d;
            err_orphan_q  <= err_orphan_d;
        end
    end

    // Owner's command lanes pass straight through; everything is zero otherwise.
    always_comb begin
        cmd         = 1'b0;
        cmd_en      = 1'b0;
        addr        = '0;
        wr_data     = '0;
        data_mask   = '0;
        rq_rd_valid = '0;
        if (state_q == ST_GRANT) begin
            cmd                  = rq_cmd[owner_q];
            cmd_en               = rq_cmd_en[owner_q];
            addr                 = rq_addr[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
            wr_data              = rq_wr_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
            data_mask            = rq_data_mask[int'(owner_q)*MASK_WIDTH +: MASK_WIDTH];
            rq_rd_valid[owner_q] = rd_data_valid;
        end
    end

    assign rq_grant    = grant_q;
    assign rq_rd_data  = rd_data;
    assign err_timeout = err_timeout_q;
    assign err_orphan  = err_orphan_q;

endmodule
